pe_array_cfg_sequencer: RTL and testbench
=========================================

Name: pe_array_cfg_sequencer

Overview:
- Parametrised configuration and run sequencer for an ROWS x COLS PE array with N_LSU top-edge LSUs.
- Accepts a valid/ready stream of (target, config word) pairs and broadcasts each word on a shared config bus.
- For each word it pulses the one-hot init strobes for the addressed PE row/column or LSU.
- After the last word it holds the array's run signal for a programmed number of cycles, then reports done.
- It replaces the fixed 13-bit packed init vector of the 4x4 array with a generic, handshaked loader.

Parameters:
- ROWS, 4, number of PE rows.
- COLS, 4, PEs per row.
- N_LSU, 4, top-edge LSUs (targets after all PEs).
- CFG_W, 64, config word width (PE instruction width).
- TGT_W, 5, target index width; must satisfy 2^TGT_W >= ROWS*COLS+N_LSU.
- RUN_W, 16, run-cycle counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins a load sequence (honoured only in IDLE).
- abort  in  1  returns to IDLE from any state.
- run_cycles  in  RUN_W  number of run cycles; sampled on accepted start.
- cfg_valid  in  1  config word valid.
- cfg_ready  out  1  config word accepted when cfg_valid && cfg_ready.
- cfg_tgt  in  TGT_W  target index.
- cfg_data  in  CFG_W  config word.
- cfg_last  in  1  marks the final word of the sequence.
- PE_config  out  CFG_W  registered broadcast config word.
- init_row  out  ROWS  one-hot row init strobe.
- init_col  out  COLS  one-hot PE-within-row select; valid with init_row.
- init_lsu  out  N_LSU  one-hot LSU init strobe.
- run  out  1  array run enable.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky flag for an out-of-range target.
- cfg_count  out  TGT_W+2  words accepted in the current sequence (saturating).

Behaviour:
- Reset (rst=1 at a clock edge), all outputs 0, state IDLE:
  - PE_config, init_row, init_col, init_lsu = 0.
  - run, busy, done, err, cfg_count = 0.
  - cfg_ready = 0.
  - rst mid-sequence aborts with no done pulse.
- States:
  - IDLE: cfg_ready=0. On start: latch run_cycles, clear err and cfg_count, go to LOAD.
  - LOAD: cfg_ready=1. Each accepted word updates the next-cycle outputs (latency 1 after the handshake edge). Rules:
    - PE_config <= cfg_data.
    - If tgt < ROWS*COLS: init_row[tgt/COLS]=1 and init_col[tgt%COLS]=1.
    - If ROWS*COLS <= tgt < ROWS*COLS+N_LSU: init_lsu[tgt-ROWS*COLS]=1.
    - Otherwise: no strobe, err <= 1, word consumed.
    - cfg_count increments on every accepted word, saturating at all-ones.
    - Strobes are 1 cycle wide. With no accept in a cycle, strobes are 0 next cycle and PE_config holds its value.
    - Back-to-back accepts produce back-to-back strobes.
    - Accepting a word with cfg_last=1 moves the state to SETTLE.
  - SETTLE: 1 cycle. cfg_ready=0. The strobe for the last word is visible here. Then:
    - if the latched run_cycles==0, go to DONE;
    - else go to RUN with the counter loaded to run_cycles.
  - RUN: run=1 for exactly run_cycles consecutive cycles; the counter decrements each cycle; at count 1 go to DONE.
  - DONE: done=1 for 1 cycle, run=0, then IDLE.
- busy=1 in LOAD, SETTLE, RUN and DONE.
- start outside IDLE is ignored.
- abort has priority over start and over the handshake in the same cycle:
  - cfg_ready=0 combinationally while abort=1.
  - Next cycle: state IDLE; run, strobes and done = 0.
  - PE_config, err and cfg_count retain their values.
- A word with cfg_valid=1 but no cfg_ready (IDLE/SETTLE/RUN) has no effect.
- done and run are never high in the same cycle.

Test Plan:
- Reset then idle, start=0, cfg_valid=1 held for 5 cycles -> cfg_ready=0 throughout; all outputs 0; busy=0.
- start with run_cycles=3; words tgt=0, 5, 15(last), data 0xA,0xB,0xC, back-to-back -> init_row/init_col go 0001/0001, 0010/0010, 1000/1000 on consecutive cycles, PE_config tracks A,B,C; SETTLE; run high exactly 3 cycles; done 1 cycle; cfg_count=3; err=0.
- Words tgt=16, 19(last) with cfg_valid gapped by 2 idle cycles -> init_lsu=0001, then init_lsu=1000; no strobes in gap cycles; init_row=0 throughout.
- tgt=25 (out of range), then tgt=2 (last) -> no strobe for 25, err=1 sticky through done; init_row=0001, init_col=0100 for the second word; err cleared by the next start.
- run_cycles=0 with a single last word tgt=0 -> strobe, SETTLE, done, run never 1.
- abort asserted on the second RUN cycle (run_cycles=10), with start also asserted during RUN -> run=0 next cycle, state IDLE, no done; start during RUN ignored; rst asserted in LOAD -> all outputs 0 next cycle.

Source files
------------

// File: rtl/pe_array_cfg_sequencer.sv
// Loads (target, word) pairs into a ROWS x COLS PE array plus top-edge LSUs, then runs it for a set cycle count.
// Strobes and PE_config appear 1 cycle after each handshake; cfg_ready is high only in LOAD and drops at once on abort.
module pe_array_cfg_sequencer #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int N_LSU = 4,
    parameter int CFG_W = 64,
    parameter int TGT_W = 5,
    parameter int RUN_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [RUN_W-1:0]   run_cycles,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [TGT_W-1:0]   cfg_tgt,
    input  logic [CFG_W-1:0]   cfg_data,
    input  logic               cfg_last,
    output logic [CFG_W-1:0]   PE_config,
    output logic [ROWS-1:0]    init_row,
    output logic [COLS-1:0]    init_col,
    output logic [N_LSU-1:0]   init_lsu,
    output logic               run,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [TGT_W+1:0]   cfg_count
);
    localparam int NPE  = ROWS * COLS;
    localparam int NTGT = NPE + N_LSU;
    localparam logic [TGT_W+1:0] CNT_ONE = {{(TGT_W+1){1'b0}}, 1'b1};
    localparam logic [RUN_W-1:0] RUN_ONE = {{(RUN_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CFG_W-1:0]   pe_config_q, pe_config_d;
    logic [ROWS-1:0]    init_row_q, init_row_d;
    logic [COLS-1:0]    init_col_q, init_col_d;
    logic [N_LSU-1:0]   init_lsu_q, init_lsu_d;
    logic               run_q, run_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [TGT_W+1:0]   cfg_count_q, cfg_count_d;
    logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
    logic               accept;
    int                 tgt_i;

    assign cfg_ready = (state_q == S_LOAD) && !abort;
    assign accept    = cfg_valid && cfg_ready;

    always_comb begin
        state_d     = state_q;
        pe_config_d = pe_config_q;
        init_row_d  = '0;
        init_col_d  = '0;
        init_lsu_d  = '0;
        run_d       = 1'b0;
        done_d      = 1'b0;
        err_d       = err_q;
        cfg_count_d = cfg_count_q;
        run_cnt_d   = run_cnt_q;
        tgt_i       = int'(cfg_tgt);

        // abort wins over everything; config word, err and count are kept for inspection
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        run_cnt_d   = run_cycles;
                        err_d       = 1'b0;
                        cfg_count_d = '0;
                        state_d     = S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        pe_config_d = cfg_data;
                        for (int r = 0; r < ROWS; r++) begin
                            init_row_d[r] = (tgt_i >= r * COLS) && (tgt_i < (r + 1) * COLS);
                            for (int c = 0; c < COLS; c++) begin
                                if (tgt_i == r * COLS + c) init_col_d[c] = 1'b1;
                            end
                        end
                        for (int l = 0; l < N_LSU; l++) begin
                            init_lsu_d[l] = (tgt_i == NPE + l);
                        end
                        if (tgt_i >= NTGT) err_d = 1'b1;
                        if (cfg_count_q != '1) cfg_count_d = cfg_count_q + CNT_ONE;
                        if (cfg_last) state_d = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (run_cnt_q == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        run_d   = 1'b1;
                    end
                end
                S_RUN: begin
                    if (run_cnt_q == RUN_ONE) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        run_d     = 1'b1;
                        run_cnt_d = run_cnt_q - RUN_ONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pe_config_q <= '0;
            init_row_q  <= '0;
            init_col_q  <= '0;
            init_lsu_q  <= '0;
            run_q       <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cfg_count_q <= '0;
            run_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            pe_config_q <= pe_config_d;
            init_row_q  <= init_row_d;
            init_col_q  <= init_col_d;
            init_lsu_q  <= init_lsu_d;
            run_q       <= run_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cfg_count_q <= cfg_count_d;
            run_cnt_q   <= run_cnt_d;
        end
    end

    assign PE_config = pe_config_q;
    assign init_row  = init_row_q;
    assign init_col  = init_col_q;
    assign init_lsu  = init_lsu_q;
    assign run       = run_q;
    assign done      = done_q;
    assign err       = err_q;
    assign cfg_count = cfg_count_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_pe_array_cfg_sequencer.sv
// Directed-vector bench for pe_array_cfg_sequencer with hand-computed expectations.
module tb_pe_array_cfg_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] run_cycles;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [4:0]  cfg_tgt;
    logic [63:0] cfg_data;
    logic        cfg_last;
    logic [63:0] PE_config;
    logic [3:0]  init_row;
    logic [3:0]  init_col;
    logic [3:0]  init_lsu;
    logic        run;
    logic        busy;
    logic        done;
    logic        err;
    logic [6:0]  cfg_count;

    int err_cnt = 0;
    int chk_cnt = 0;

    pe_array_cfg_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .run_cycles(run_cycles),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_tgt(cfg_tgt), .cfg_data(cfg_data),
        .cfg_last(cfg_last), .PE_config(PE_config), .init_row(init_row), .init_col(init_col),
        .init_lsu(init_lsu), .run(run), .busy(busy), .done(done), .err(err), .cfg_count(cfg_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // strobes / run / done / busy as one tuple
    task automatic chk_out(input string tag, input logic [3:0] row, input logic [3:0] col,
                           input logic [3:0] lsu, input logic r, input logic d, input logic b);
        chk({tag, ".row"},  {60'd0, init_row}, {60'd0, row});
        chk({tag, ".col"},  {60'd0, init_col}, {60'd0, col});
        chk({tag, ".lsu"},  {60'd0, init_lsu}, {60'd0, lsu});
        chk({tag, ".run"},  {63'd0, run},  {63'd0, r});
        chk({tag, ".done"}, {63'd0, done}, {63'd0, d});
        chk({tag, ".busy"}, {63'd0, busy}, {63'd0, b});
    endtask

    task automatic word(input logic [4:0] t, input logic [63:0] d, input logic l);
        cfg_valid = 1'b1;
        cfg_tgt   = t;
        cfg_data  = d;
        cfg_last  = l;
    endtask

    task automatic begin_seq(input logic [15:0] rc);
        run_cycles = rc;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; run_cycles = '0;
        cfg_valid = 1'b0; cfg_tgt = '0; cfg_data = '0; cfg_last = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk_out("reset", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.cfg", PE_config, 64'd0);
        chk("reset.err", {63'd0, err}, 64'd0);
        chk("reset.count", {57'd0, cfg_count}, 64'd0);

        // idle: valid without start is never accepted
        word(5'd3, 64'h55, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("idle.ready", {63'd0, cfg_ready}, 64'd0);
            step();
            chk_out("idle", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("idle.cfg", PE_config, 64'd0);
        cfg_valid = 1'b0;

        // back-to-back PE words, run 3
        begin_seq(16'd3);
        chk("t2.busy", {63'd0, busy}, 64'd1);
        word(5'd0, 64'hA, 1'b0);
        #1 chk("t2.ready", {63'd0, cfg_ready}, 64'd1);
        step();
        chk_out("t2.w0", 4'b0001, 4'b0001, 4'b0, 1'b0, 1'b0, 1'b1);
        chk("t2.cfg0", PE_config, 64'hA);
        word(5'd5, 64'hB, 1'b0);
        step();
        chk_out("t2.w1", 4'b0010, 4'b0010, 4'b0, 1'b0, 1'b0, 1'b1);
        chk("t2.cfg1", PE_config, 64'hB);
        word(5'd15, 64'hC, 1'b1);
        step();
        cfg_valid = 1'b0;
        chk_out("t2.settle", 4'b1000, 4'b1000, 4'b0, 1'b0, 1'b0, 1'b1);
        chk("t2.cfg2", PE_config, 64'hC);
        #1 chk("t2.settle_rdy", {63'd0, cfg_ready}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("t2.run", 4'b0, 4'b0, 4'b0, 1'b1, 1'b0, 1'b1);
        end
        step();
        chk_out("t2.done", 4'b0, 4'b0, 4'b0, 1'b0, 1'b1, 1'b1);
        chk("t2.count", {57'd0, cfg_count}, 64'd3);
        chk("t2.err", {63'd0, err}, 64'd0);
        step();
        chk_out("t2.idle", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);

        // LSU words with a 2-cycle valid gap
        begin_seq(16'd1);
        word(5'd16, 64'h10, 1'b0);
        step();
        cfg_valid = 1'b0;
        chk_out("t3.lsu0", 4'b0, 4'b0, 4'b0001, 1'b0, 1'b0, 1'b1);
        step();
        chk_out("t3.gap0", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b1);
        chk("t3.hold", PE_config, 64'h10);
        step();
        chk_out("t3.gap1", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b1);
        word(5'd19, 64'h13, 1'b1);
        step();
        cfg_valid = 1'b0;
        chk_out("t3.lsu3", 4'b0, 4'b0, 4'b1000, 1'b0, 1'b0, 1'b1);
        step();
        chk_out("t3.run", 4'b0, 4'b0, 4'b0, 1'b1, 1'b0, 1'b1);
        step();
        chk_out("t3.done", 4'b0, 4'b0, 4'b0, 1'b0, 1'b1, 1'b1);
        chk("t3.count", {57'd0, cfg_count}, 64'd2);
        step();

        // out-of-range target then valid last word; err sticky
        begin_seq(16'd2);
        word(5'd25, 64'h25, 1'b0);
        step();
        chk_out("t4.oor", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b1);
        chk("t4.err_set", {63'd0, err}, 64'd1);
        word(5'd2, 64'h2, 1'b1);
        step();
        cfg_valid = 1'b0;
        chk_out("t4.w2", 4'b0001, 4'b0100, 4'b0, 1'b0, 1'b0, 1'b1);
        step();
        chk("t4.run0", {63'd0, run}, 64'd1);
        step();
        chk("t4.run1", {63'd0, run}, 64'd1);
        step();
        chk_out("t4.done", 4'b0, 4'b0, 4'b0, 1'b0, 1'b1, 1'b1);
        chk("t4.err_done", {63'd0, err}, 64'd1);
        step();
        chk("t4.err_idle", {63'd0, err}, 64'd1);

        // run_cycles = 0: strobe, settle, done, no run
        begin_seq(16'd0);
        chk("t5.err_clr", {63'd0, err}, 64'd0);
        chk("t5.cnt_clr", {57'd0, cfg_count}, 64'd0);
        word(5'd0, 64'h99, 1'b1);
        step();
        cfg_valid = 1'b0;
        chk_out("t5.settle", 4'b0001, 4'b0001, 4'b0, 1'b0, 1'b0, 1'b1);
        step();
        chk_out("t5.done", 4'b0, 4'b0, 4'b0, 1'b0, 1'b1, 1'b1);
        step();
        chk_out("t5.idle", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        chk("t5.count", {57'd0, cfg_count}, 64'd1);

        // abort on 2nd RUN cycle, start during RUN ignored
        begin_seq(16'd10);
        word(5'd1, 64'h77, 1'b1);
        step();
        cfg_valid = 1'b0;
        step();
        chk("t6.run1", {63'd0, run}, 64'd1);
        start = 1'b1;
        step();
        chk("t6.run2", {63'd0, run}, 64'd1);
        chk("t6.busy2", {63'd0, busy}, 64'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        chk_out("t6.abort", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        chk("t6.cfg", PE_config, 64'h77);
        chk("t6.count", {57'd0, cfg_count}, 64'd1);
        step();
        chk_out("t6.after", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);

        // abort during LOAD blocks the handshake combinationally
        begin_seq(16'd5);
        word(5'd3, 64'h33, 1'b0);
        step();
        chk_out("t7.w3", 4'b0001, 4'b1000, 4'b0, 1'b0, 1'b0, 1'b1);
        word(5'd4, 64'h44, 1'b0);
        abort = 1'b1;
        #1 chk("t7.abort_rdy", {63'd0, cfg_ready}, 64'd0);
        step();
        abort = 1'b0;
        cfg_valid = 1'b0;
        chk_out("t7.abort", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        chk("t7.cfg", PE_config, 64'h33);
        chk("t7.count", {57'd0, cfg_count}, 64'd1);

        // reset in LOAD clears everything
        begin_seq(16'd5);
        word(5'd6, 64'h66, 1'b0);
        step();
        chk_out("t8.w6", 4'b0010, 4'b0100, 4'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_out("t8.rst", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        chk("t8.cfg", PE_config, 64'd0);
        chk("t8.count", {57'd0, cfg_count}, 64'd0);
        #1 chk("t8.ready", {63'd0, cfg_ready}, 64'd0);
        cfg_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
